// File: rtl/tc140l_pkg.sv
// Shared constants for the tc140l memory arbiter: default widths, FSM state
// encoding and requester owner codes.
package tc140l_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_WR_HOLD = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD      = ST_RD,
    RD_DATA = ST_RD_DATA,
    WR      = ST_WR,
    WR_HOLD = ST_WR_HOLD
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_HST = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: a lone requester always wins; on contention
// the CPU wins in fixed mode, otherwise whoever did not own the last access.
module rr_pick2
  import tc140l_pkg::*;
(
  input  logic [1:0] req_i,        // [0] = CPU, [1] = host
  input  owner_e     last_owner_i,
  input  logic       fixed_i,
  output owner_e     winner_o
);

  always_comb begin
    winner_o = OWN_CPU;
    case (req_i)
      2'b10: winner_o = OWN_HST;
      2'b11: begin
        if (fixed_i || last_owner_i == OWN_HST) winner_o = OWN_CPU;
        else                                    winner_o = OWN_HST;
      end
      default: winner_o = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/tc140l_mem_arbiter.sv
// Arbitrates the single-port program/data RAM between the tc140l CPU and the
// host loader, sequencing each access as a read or write cycle with a stable address.
module tc140l_mem_arbiter
  import tc140l_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          hst_req,
  input  logic          hst_we,
  input  logic [AW-1:0] hst_addr,
  input  logic [DW-1:0] hst_wdata,
  output logic          hst_gnt,
  output logic          hst_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q
);

  state_e        state_q, state_d;
  owner_e        last_owner_q, last_owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  owner_e        winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req_i       ({hst_req, cpu_req}),
    .last_owner_i(last_owner_q),
    .fixed_i     (FIXED_PRIO),
    .winner_o    (winner)
  );

  always_comb begin
    if (winner == OWN_CPU) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end else begin
      sel_we    = hst_we;
      sel_addr  = hst_addr;
      sel_wdata = hst_wdata;
    end
  end

  // NOTE: every next-state signal takes its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || hst_req) begin
          last_owner_d = winner;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          state_d      = sel_we ? WR : RD;
        end
      end
      RD: begin
        rdata_d = mem_q;  // captured on entry to RD_DATA so rdata is stable all cycle
        state_d = RD_DATA;
      end
      RD_DATA: state_d = IDLE;
      WR:      state_d = WR_HOLD;
      WR_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_HST;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Strobes decode straight from the state register, so reset kills wren without waiting for a clock.
  assign mem_we     = (state_q == WR);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rdata      = rdata_q;

  assign cpu_gnt    = (state_q == RD || state_q == WR) && (last_owner_q == OWN_CPU);
  assign hst_gnt    = (state_q == RD || state_q == WR) && (last_owner_q == OWN_HST);
  assign cpu_rvalid = (state_q == RD_DATA) && (last_owner_q == OWN_CPU);
  assign hst_rvalid = (state_q == RD_DATA) && (last_owner_q == OWN_HST);

endmodule

// File: tb/tb_tc140l_mem_arbiter.sv
// Bench for tc140l_mem_arbiter: behavioural RAM, read-data scoreboard and
// cycle-exact checks of grant timing, arbitration and reset abort.
module tb_tc140l_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          hst_req = 1'b0, hst_we = 1'b0;
  logic [AW-1:0] hst_addr = '0;
  logic [DW-1:0] hst_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, hst_gnt, hst_rvalid, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_q;
  logic [AW-1:0] mem_addr;

  logic          fp_cpu_req = 1'b0, fp_hst_req = 1'b0;
  logic          fp_cpu_gnt, fp_cpu_rvalid, fp_hst_gnt, fp_hst_rvalid, fp_mem_we;
  logic [DW-1:0] fp_rdata, fp_mem_wdata, fp_mem_q;
  logic [AW-1:0] fp_mem_addr;

  typedef struct {
    logic          is_hst;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] ram[256];
  logic [DW-1:0] mdl[256];
  int            total = 0;
  int            bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_q    = ram[mem_addr];
  assign fp_mem_q = ram[fp_mem_addr];

  tc140l_mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_gnt(hst_gnt), .hst_rvalid(hst_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q)
  );

  tc140l_mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(fp_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(fp_cpu_gnt), .cpu_rvalid(fp_cpu_rvalid),
    .hst_req(fp_hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_gnt(fp_hst_gnt), .hst_rvalid(fp_hst_rvalid),
    .rdata(fp_rdata), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we),
    .mem_q(fp_mem_q)
  );

  // One clock, then sample 1 ns later; read results are checked against the scoreboard here.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    total++;
    if ((cpu_gnt && hst_gnt) || (cpu_rvalid && hst_rvalid)) begin
      bad++;
      $display("FAIL excl_pulse: gnt=%b%b rvalid=%b%b, required at most one owner", cpu_gnt, hst_gnt,
               cpu_rvalid, hst_rvalid);
    end
    if (cpu_rvalid || hst_rvalid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: rvalid cpu=%b hst=%b rdata=%h, required no read", cpu_rvalid,
                 hst_rvalid, rdata);
      end else begin
        e = sb_q.pop_front();
        if (hst_rvalid !== e.is_hst || rdata !== e.data) begin
          bad++;
          $display("FAIL sb_read: hst=%b rdata=%h, required hst=%b rdata=%h", hst_rvalid, rdata,
                   e.is_hst, e.data);
        end
      end
    end
  endtask

  task automatic push_read(input logic is_hst, input logic [AW-1:0] a);
    exp_t e;
    e.is_hst = is_hst;
    e.data   = mdl[a];
    sb_q.push_back(e);
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_hst(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    hst_req = r; hst_we = w; hst_addr = a; hst_wdata = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0; hst_req = 1'b0; fp_cpu_req = 1'b0; fp_hst_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({cpu_gnt, hst_gnt, cpu_rvalid, hst_rvalid, mem_we} !== 5'b0) begin
      bad++;
      $display("FAIL reset_strobes: gnt/rvalid/we=%b, required 00000",
               {cpu_gnt, hst_gnt, cpu_rvalid, hst_rvalid, mem_we});
    end
    total++;
    if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000 || rdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_regs: addr=%h wdata=%h rdata=%h, required 00 0000 0000", mem_addr,
               mem_wdata, rdata);
    end
    tick();
    total++;
    if ({cpu_gnt, hst_gnt, mem_we} !== 3'b0) begin
      bad++;
      $display("FAIL reset_idle: gnt=%b%b we=%b, required 000", cpu_gnt, hst_gnt, mem_we);
    end
  endtask

  task automatic test_cpu_read();
    set_cpu(1'b1, 1'b0, 8'h10, 16'h0);
    push_read(1'b0, 8'h10);
    tick();
    total++;
    if (cpu_gnt !== 1'b1 || hst_gnt !== 1'b0 || mem_addr !== 8'h10 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL cpu_rd_gnt: gnt=%b%b addr=%h we=%b, required 10 10 0", cpu_gnt, hst_gnt,
               mem_addr, mem_we);
    end
    cpu_req = 1'b0;
    tick();
    total++;
    if ({cpu_rvalid, hst_rvalid, cpu_gnt, hst_gnt} !== 4'b1000) begin
      bad++;
      $display("FAIL cpu_rd_valid: rvalid=%b%b gnt=%b%b, required 10 00", cpu_rvalid, hst_rvalid,
               cpu_gnt, hst_gnt);
    end
    tick();
    total++;
    if ({cpu_rvalid, hst_rvalid, cpu_gnt, hst_gnt} !== 4'b0000) begin
      bad++;
      $display("FAIL cpu_rd_idle: rvalid=%b%b gnt=%b%b, required 0000", cpu_rvalid, hst_rvalid,
               cpu_gnt, hst_gnt);
    end
  endtask

  task automatic test_host_write_read();
    set_hst(1'b1, 1'b1, 8'h20, 16'hBEEF);
    mdl[8'h20] = 16'hBEEF;
    tick();
    total++;
    if (hst_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h20 ||
        mem_wdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL hst_wr: gnt=%b%b we=%b addr=%h wdata=%h, required 01 1 20 beef", cpu_gnt,
               hst_gnt, mem_we, mem_addr, mem_wdata);
    end
    hst_req = 1'b0;
    tick();
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 8'h20 || hst_gnt !== 1'b0) begin
      bad++;
      $display("FAIL hst_wr_hold: we=%b addr=%h gnt=%b, required 0 20 0", mem_we, mem_addr, hst_gnt);
    end
    tick();
    total++;
    if (mem_we !== 1'b0) begin
      bad++;
      $display("FAIL hst_wr_once: we=%b, required 0", mem_we);
    end
    set_cpu(1'b1, 1'b0, 8'h20, 16'h0);
    push_read(1'b0, 8'h20);
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_c, exp_h;
    do_reset();
    set_cpu(1'b1, 1'b0, 8'h11, 16'h0);
    set_hst(1'b1, 1'b0, 8'h12, 16'h0);
    push_read(1'b0, 8'h11);
    push_read(1'b1, 8'h12);
    push_read(1'b0, 8'h11);
    push_read(1'b1, 8'h12);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      exp_c = (cyc == 1 || cyc == 7);
      exp_h = (cyc == 4 || cyc == 10);
      total++;
      if ({cpu_gnt, hst_gnt} !== {exp_c, exp_h}) begin
        bad++;
        $display("FAIL rr_gnt cyc%0d: gnt=%b%b, required %b%b", cyc, cpu_gnt, hst_gnt, exp_c, exp_h);
      end
      if (cyc == 10) begin
        cpu_req = 1'b0;
        hst_req = 1'b0;
      end
    end
  endtask

  task automatic test_fixed_prio();
    logic exp_c, exp_h;
    do_reset();
    set_cpu(1'b0, 1'b0, 8'h13, 16'h0);
    set_hst(1'b0, 1'b0, 8'h14, 16'h0);
    fp_cpu_req = 1'b1;
    fp_hst_req = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      tick();
      exp_c = (cyc == 1 || cyc == 4 || cyc == 7);
      exp_h = (cyc == 10);
      total++;
      if ({fp_cpu_gnt, fp_hst_gnt} !== {exp_c, exp_h}) begin
        bad++;
        $display("FAIL fp_gnt cyc%0d: gnt=%b%b, required %b%b", cyc, fp_cpu_gnt, fp_hst_gnt, exp_c,
                 exp_h);
      end
      if (cyc == 7) fp_cpu_req = 1'b0;
      if (cyc == 10) fp_hst_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_write();
    set_hst(1'b1, 1'b1, 8'h40, 16'hAAAA);
    tick();
    total++;
    if (mem_we !== 1'b1 || hst_gnt !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: we=%b gnt=%b, required 1 1", mem_we, hst_gnt);
    end
    #2;
    reset_n = 1'b0;
    hst_req = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0 || hst_gnt !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: we=%b gnt=%b, required 0 0", mem_we, hst_gnt);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      total++;
      if ({cpu_gnt, hst_gnt, cpu_rvalid, hst_rvalid, mem_we} !== 5'b0 || mem_addr !== 8'h00) begin
        bad++;
        $display("FAIL abort_quiet cyc%0d: strobes=%b addr=%h, required 00000 00", cyc,
                 {cpu_gnt, hst_gnt, cpu_rvalid, hst_rvalid, mem_we}, mem_addr);
      end
    end
    set_cpu(1'b1, 1'b0, 8'h40, 16'h0);
    push_read(1'b0, 8'h40);
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_addr_change();
    set_hst(1'b1, 1'b0, 8'h30, 16'h0);
    push_read(1'b1, 8'h30);
    tick();
    total++;
    if (hst_gnt !== 1'b1 || mem_addr !== 8'h30) begin
      bad++;
      $display("FAIL addr_chg_gnt: gnt=%b addr=%h, required 1 30", hst_gnt, mem_addr);
    end
    hst_addr = 8'h31;
    hst_req  = 1'b0;
    tick();
    total++;
    if (mem_addr !== 8'h30) begin
      bad++;
      $display("FAIL addr_chg_hold: addr=%h, required 30", mem_addr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_c;
    set_cpu(1'b1, 1'b1, 8'h50, 16'h7777);
    mdl[8'h50] = 16'h7777;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      exp_c = (cyc == 1 || cyc == 4);
      total++;
      if (cpu_gnt !== exp_c || mem_we !== (cyc == 1)) begin
        bad++;
        $display("FAIL b2b cyc%0d: gnt=%b we=%b, required %b %b", cyc, cpu_gnt, mem_we, exp_c,
                 (cyc == 1));
      end
      if (cyc == 1) begin
        cpu_we = 1'b0;
        push_read(1'b0, 8'h50);
      end
      if (cyc == 4) cpu_req = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'(i * 257) ^ 16'h5A5A;
      mdl[i] = 16'(i * 257) ^ 16'h5A5A;
    end
    ram[8'h10] = 16'h1234;
    mdl[8'h10] = 16'h1234;

    test_reset();
    test_cpu_read();
    test_host_write_read();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_write();
    test_addr_change();
    test_back_to_back();
    repeat (2) tick();

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: pending=%0d, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded 100000 ns, required completion");
    $fatal(1, "watchdog");
  end

endmodule
